// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: preemption FSM states
// and the 4-bit light output codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_FIRE    = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam logic [3:0] LIGHT_RED      = 4'b0001;
  localparam logic [3:0] LIGHT_YELLOW   = 4'b0010;
  localparam logic [3:0] LIGHT_GREEN    = 4'b0100;
  localparam logic [3:0] LIGHT_LEFT_RED = 4'b1001;

  localparam int LIGHT_BIT_RED    = 0;
  localparam int LIGHT_BIT_YELLOW = 1;
  localparam int LIGHT_BIT_GREEN  = 2;
  localparam int LIGHT_BIT_LEFT   = 3;

endpackage

// File: rtl/detect_qualifier.sv
// Counts consecutive high detector samples; qualified flags the sample that
// completes a run of DEBOUNCE highs while the FSM is listening (arm).
module detect_qualifier #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic detect,
  output logic qualified
);

  localparam int QW = $clog2(DEBOUNCE + 1);

  logic [QW-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (rst || !arm || !detect) begin
      run_cnt <= '0;
    end else if (run_cnt != QW'(DEBOUNCE)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // run_cnt holds the highs already seen; this sample makes it one more.
  assign qualified = arm && detect && ((int'(run_cnt) + 1) >= DEBOUNCE);

endmodule

// File: rtl/emergency_dispatch.sv
// Emergency-vehicle preemption initiator: qualifies the detector, pulses both
// light controllers, confirms all-red, and re-fires after a cooldown.
module emergency_dispatch
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE        = 3,
  parameter int CONFIRM_TIMEOUT = 2,
  parameter int HOLDOFF         = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             detect,
  input  logic [3:0]       ns_light,
  input  logic [3:0]       ew_light,
  output logic             emergency,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] events
);

  localparam int TMAX = (CONFIRM_TIMEOUT > HOLDOFF) ? CONFIRM_TIMEOUT : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state, state_nxt;
  logic [TW-1:0] conf_cnt;
  logic [TW-1:0] hold_cnt;
  logic          qualified;
  logic          arm;
  logic          all_red;
  logic          conf_last;
  logic          hold_last;
  logic          fault_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign arm = (state == ST_IDLE) || (state == ST_QUALIFY);

  detect_qualifier #(
    .DEBOUNCE(DEBOUNCE)
  ) u_qual (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .detect   (detect),
    .qualified(qualified)
  );

  assign all_red   = (ns_light == LIGHT_RED) && (ew_light == LIGHT_RED);
  assign conf_last = (conf_cnt == TW'(CONFIRM_TIMEOUT - 1));
  assign hold_last = (hold_cnt == TW'(HOLDOFF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      conf_cnt <= '0;
      hold_cnt <= '0;
      fault    <= 1'b0;
      events   <= '0;
    end else begin
      state    <= state_nxt;
      conf_cnt <= (state == ST_CONFIRM) ? conf_cnt + 1'b1 : '0;
      hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + 1'b1 : '0;
      if (fault_set) begin
        fault <= 1'b1;
      end
      if (state == ST_FIRE) begin
        events <= sat_inc(events);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fault_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (qualified) begin
          state_nxt = ST_FIRE;
        end else if (detect) begin
          state_nxt = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (!detect) begin
          state_nxt = ST_IDLE;
        end else if (qualified) begin
          state_nxt = ST_FIRE;
        end
      end
      ST_FIRE: begin
        state_nxt = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        // All-red on the last allowed cycle still counts as confirmed.
        if (all_red) begin
          state_nxt = ST_HOLDOFF;
        end else if (conf_last) begin
          fault_set = 1'b1;
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (hold_last) begin
          state_nxt = detect ? ST_FIRE : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign emergency = (state == ST_FIRE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_emergency_dispatch.sv
// Randomized and scenario stimulus for emergency_dispatch, checked every cycle
// against a countdown-based reference model of the preemption sequence.
module tb_emergency_dispatch;
  import traffic_pkg::*;

  localparam int DEB   = 3;
  localparam int CT    = 2;
  localparam int HO    = 4;
  localparam int CW    = 2;
  localparam int EVMAX = (1 << CW) - 1;

  localparam int M_WAIT  = 0;
  localparam int M_COUNT = 1;
  localparam int M_PULSE = 2;
  localparam int M_CHECK = 3;
  localparam int M_COOL  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          detect = 1'b0;
  logic [3:0]    ns_light = 4'b0000;
  logic [3:0]    ew_light = 4'b0000;
  logic          emergency;
  logic          busy;
  logic          fault;
  logic [CW-1:0] events;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int m_mode = M_WAIT;
  int m_streak = 0;
  int m_left = 0;
  int m_ev = 0;
  int m_fault = 0;

  int last_pulse = -1;
  int prev_emerg = 0;

  emergency_dispatch #(
    .DEBOUNCE       (DEB),
    .CONFIRM_TIMEOUT(CT),
    .HOLDOFF        (HO),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .detect   (detect),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .emergency(emergency),
    .busy     (busy),
    .fault    (fault),
    .events   (events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock of the preemption sequence described in plain countdowns.
  task automatic model_edge(input logic r, input logic d, input logic [3:0] ns, input logic [3:0] ew);
    if (r) begin
      m_mode = M_WAIT; m_streak = 0; m_left = 0; m_ev = 0; m_fault = 0;
    end else begin
      case (m_mode)
        M_WAIT, M_COUNT: begin
          if (!d) begin
            m_streak = 0;
            m_mode = M_WAIT;
          end else begin
            m_streak++;
            m_mode = (m_streak >= DEB) ? M_PULSE : M_COUNT;
          end
        end
        M_PULSE: begin
          m_streak = 0;
          if (m_ev < EVMAX) m_ev++;
          m_mode = M_CHECK;
          m_left = CT;
        end
        M_CHECK: begin
          if (ns == LIGHT_RED && ew == LIGHT_RED) begin
            m_mode = M_COOL; m_left = HO;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_fault = 1; m_mode = M_COOL; m_left = HO;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = d ? M_PULSE : M_WAIT;
        end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [3:0] ns, input logic [3:0] ew);
    rst = r; detect = d; ns_light = ns; ew_light = ew;
    @(posedge clk);
    model_edge(r, d, ns, ew);
    #1;
    cyc++;
    chk("emergency", 32'(emergency), 32'(m_mode == M_PULSE));
    chk("busy",      32'(busy),      32'(m_mode != M_WAIT));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("events",    32'(events),    32'(m_ev));
    if (emergency && prev_emerg != 0) chk("adjacent_pulse", 32'(1), 32'(0));
    prev_emerg = int'(emergency);
  endtask

  function automatic logic [3:0] rand_light();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 7) return LIGHT_RED;
    if (k == 7) return LIGHT_GREEN;
    if (k == 8) return LIGHT_YELLOW;
    return LIGHT_LEFT_RED;
  endfunction

  initial begin
    int rnd_det;

    step(1'b1, 1'b0, LIGHT_RED, LIGHT_RED);
    step(1'b1, 1'b1, LIGHT_RED, LIGHT_RED);
    chk("reset_events", 32'(events), 32'(0));

    // Glitch rejection: two highs then low.
    step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
    step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, LIGHT_RED, LIGHT_RED);
    chk("glitch_busy", 32'(busy), 32'(0));
    chk("glitch_events", 32'(events), 32'(0));

    // Single request with all-red the cycle after the pulse.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, LIGHT_GREEN, LIGHT_GREEN);
    chk("single_pulse", 32'(emergency), 32'(1));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, LIGHT_RED, LIGHT_RED);
    chk("single_events", 32'(events), 32'(1));
    chk("single_idle", 32'(busy), 32'(0));

    // Sustained request: pulses exactly six cycles apart, events saturate.
    step(1'b1, 1'b0, LIGHT_RED, LIGHT_RED);
    last_pulse = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
      if (emergency) begin
        if (last_pulse >= 0) chk("spacing", 32'(cyc - last_pulse), 32'(1 + 1 + HO));
        last_pulse = cyc;
      end
    end
    chk("saturate", 32'(events), 32'(EVMAX));

    // Confirm timeout, then fault stays through later good pulses.
    step(1'b1, 1'b0, LIGHT_RED, LIGHT_RED);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, LIGHT_GREEN, LIGHT_RED);
    chk("timeout_fault", 32'(fault), 32'(1));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
    chk("fault_sticky", 32'(fault), 32'(1));

    // Reset during CONFIRM with detect high.
    step(1'b1, 1'b0, LIGHT_RED, LIGHT_RED);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, LIGHT_GREEN, LIGHT_GREEN);
    step(1'b1, 1'b1, LIGHT_GREEN, LIGHT_GREEN);
    chk("midrst_busy", 32'(busy), 32'(0));
    step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
    step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
    chk("requal_nopulse", 32'(emergency), 32'(0));
    step(1'b0, 1'b1, LIGHT_RED, LIGHT_RED);
    chk("requal_pulse", 32'(emergency), 32'(1));

    // Random traffic: runs of detect, mostly-red lights, rare resets.
    rnd_det = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rnd_det = 1 - rnd_det;
      step(($urandom_range(0, 199) == 0), rnd_det[0], rand_light(), rand_light());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
